// File: rtl/integration_feeder.sv
// Upstream feeder for the integration register file: Avalon-ST samples are buffered in a FIFO and replayed
// as Avalon-MM data writes, then followed by a single clear write on request. Optional macro: FEEDER_STATS_EN.
module integration_feeder #(
    parameter int unsigned N         = 32,
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  ADDR_DATA = 8'd0,
    parameter logic [7:0]  ADDR_CLR  = 8'd1
) (
    input  logic         csi_clk,
    input  logic         rsi_srst_n,
    input  logic [N-1:0] asi_in_data,
    input  logic         asi_in_valid,
    output logic         asi_in_ready,
    input  logic         coe_clr,
    output logic [7:0]   avm_m0_address,
    output logic         avm_m0_write,
    output logic [N-1:0] avm_m0_writedata,
    input  logic         avm_m0_waitrequest,
    output logic         coe_busy
`ifdef FEEDER_STATS_EN
    ,
    output logic [31:0]  coe_wr_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        CLR  = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  rd_nxt;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_kept;
    logic [CW-1:0]  count_nxt;
    logic [N-1:0]   head_nxt;
    logic           clr_pending;
    logic           clr_nxt;
    logic           push;
    logic           pop;
    logic           clr_done;

    // Handshakes and the FIFO view as it will be after this edge.
    // head_nxt bypasses the memory when the entry being pushed becomes the head.
    always_comb begin
        push       = asi_in_valid && asi_in_ready;
        pop        = (state == WR) && avm_m0_write && !avm_m0_waitrequest;
        clr_done   = (state == CLR) && avm_m0_write && !avm_m0_waitrequest;
        count_kept = count - CW'(pop);
        count_nxt  = count_kept + CW'(push);
        rd_nxt     = rd_ptr + AW'(pop);
        head_nxt   = (count_kept == '0) ? asi_in_data : mem[rd_nxt];
        clr_nxt    = clr_done ? 1'b0 : (clr_pending || coe_clr);
    end

    always_ff @(posedge csi_clk) begin
        if (push) begin
            mem[wr_ptr] <= asi_in_data;
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_srst_n) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            clr_pending      <= 1'b0;
            asi_in_ready     <= 1'b1;
            coe_busy         <= 1'b0;
            avm_m0_write     <= 1'b0;
            avm_m0_address   <= 8'd0;
            avm_m0_writedata <= '0;
        end else begin
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_nxt;
            count        <= count_nxt;
            clr_pending  <= clr_nxt;
            asi_in_ready <= (count_nxt != CW'(DEPTH)) && !clr_nxt;
            // Work outstanding next cycle is either buffered data or an unfinished clear.
            coe_busy     <= (count_nxt != '0) || clr_nxt;

            unique case (state)
                IDLE: begin
                    if (clr_pending && (count == '0)) begin
                        state            <= CLR;
                        avm_m0_write     <= 1'b1;
                        avm_m0_address   <= ADDR_CLR;
                        avm_m0_writedata <= '0;
                    end else if (count_nxt != '0) begin
                        state            <= WR;
                        avm_m0_write     <= 1'b1;
                        avm_m0_address   <= ADDR_DATA;
                        avm_m0_writedata <= head_nxt;
                    end
                end
                WR: begin
                    if (pop) begin
                        if (count_nxt != '0) begin
                            avm_m0_writedata <= head_nxt;
                        end else begin
                            state        <= IDLE;
                            avm_m0_write <= 1'b0;
                        end
                    end
                end
                CLR: begin
                    if (clr_done) begin
                        state        <= IDLE;
                        avm_m0_write <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    avm_m0_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef FEEDER_STATS_EN
    // Completed data writes since reset or the last clear write.
    always_ff @(posedge csi_clk) begin
        if (!rsi_srst_n) begin
            coe_wr_count <= 32'd0;
        end else if (clr_done) begin
            coe_wr_count <= 32'd0;
        end else if (pop) begin
            coe_wr_count <= coe_wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_integration_feeder.sv
// Directed self-checking bench for integration_feeder; honours FEEDER_STATS_EN when defined.
module tb_integration_feeder;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         clr;
    logic [7:0]   address;
    logic         write;
    logic [N-1:0] writedata;
    logic         waitrequest;
    logic         busy;
`ifdef FEEDER_STATS_EN
    logic [31:0]  wr_count;
`endif

    int errors = 0;
    int checks = 0;

    integration_feeder #(
        .N(N), .DEPTH(8), .ADDR_DATA(8'd0), .ADDR_CLR(8'd1)
    ) dut (
        .csi_clk            (clk),
        .rsi_srst_n         (rst_n),
        .asi_in_data        (in_data),
        .asi_in_valid       (in_valid),
        .asi_in_ready       (in_ready),
        .coe_clr            (clr),
        .avm_m0_address     (address),
        .avm_m0_write       (write),
        .avm_m0_writedata   (writedata),
        .avm_m0_waitrequest (waitrequest),
        .coe_busy           (busy)
`ifdef FEEDER_STATS_EN
        ,
        .coe_wr_count       (wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; clr = 1'b0; waitrequest = 1'b0;
        tick();
        tick();
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_addr", 64'(address), 64'd0);
        chk("rst_data", 64'(writedata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef FEEDER_STATS_EN
        chk("rst_count", 64'(wr_count), 64'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("rel_ready", 64'(in_ready), 64'd1);

        // basic flow: one sample, one cycle latency
        in_data = 32'd55; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("basic_write", 64'(write), 64'd1);
        chk("basic_addr", 64'(address), 64'd0);
        chk("basic_data", 64'(writedata), 64'd55);
        chk("basic_busy", 64'(busy), 64'd1);
        tick();
        chk("basic_done_write", 64'(write), 64'd0);
        chk("basic_done_busy", 64'(busy), 64'd0);

        // back-to-back burst
        for (int v = 1; v <= 4; v++) begin
            in_data = 32'(v); in_valid = 1'b1;
            tick();
            chk("burst_write", 64'(write), 64'd1);
            chk("burst_addr", 64'(address), 64'd0);
            chk("burst_data", 64'(writedata), 64'(v));
        end
        in_valid = 1'b0;
        tick();
        chk("burst_end_write", 64'(write), 64'd0);
        chk("burst_end_busy", 64'(busy), 64'd0);
`ifdef FEEDER_STATS_EN
        chk("count_5", 64'(wr_count), 64'd5);
`endif

        // backpressure fills the FIFO at 8 entries
        waitrequest = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'(10 + i); in_valid = 1'b1;
            chk("fill_ready", 64'(in_ready), (i < 8) ? 64'd1 : 64'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("fill_write", 64'(write), 64'd1);
        chk("fill_hold_data", 64'(writedata), 64'd10);
        tick();
        chk("fill_hold_data2", 64'(writedata), 64'd10);
        chk("fill_hold_addr", 64'(address), 64'd0);
        waitrequest = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("drain_write", 64'(write), 64'd1);
            chk("drain_data", 64'(writedata), 64'(10 + k));
            tick();
        end
        chk("drain_end_write", 64'(write), 64'd0);
        chk("drain_end_busy", 64'(busy), 64'd0);
`ifdef FEEDER_STATS_EN
        chk("count_13", 64'(wr_count), 64'd13);
`endif

        // clear ordering: samples then one clear write
        in_data = 32'd22; in_valid = 1'b1;
        tick();
        chk("clr_d22", 64'(writedata), 64'd22);
        in_data = 32'd33;
        tick();
        chk("clr_d33", 64'(writedata), 64'd33);
        chk("clr_ready_before", 64'(in_ready), 64'd1);
        in_data = 32'd44; clr = 1'b1;
        tick();
        in_valid = 1'b0; clr = 1'b0;
        chk("clr_d44", 64'(writedata), 64'd44);
        chk("clr_d44_addr", 64'(address), 64'd0);
        chk("clr_ready_low", 64'(in_ready), 64'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_gap_write", 64'(write), 64'd0);
        chk("clr_gap_ready", 64'(in_ready), 64'd0);
        chk("clr_gap_busy", 64'(busy), 64'd1);
        tick();
        chk("clr_write", 64'(write), 64'd1);
        chk("clr_addr", 64'(address), 64'd1);
        chk("clr_data", 64'(writedata), 64'd0);
        chk("clr_ready_pend", 64'(in_ready), 64'd0);
`ifdef FEEDER_STATS_EN
        chk("count_16", 64'(wr_count), 64'd16);
`endif
        tick();
        chk("clr_done_write", 64'(write), 64'd0);
        chk("clr_done_ready", 64'(in_ready), 64'd1);
        chk("clr_done_busy", 64'(busy), 64'd0);
`ifdef FEEDER_STATS_EN
        chk("count_cleared", 64'(wr_count), 64'd0);
`endif
        tick();
        chk("no_second_clr", 64'(write), 64'd0);
        tick();
        chk("no_second_clr2", 64'(write), 64'd0);

        // reset while a write is stalled
        waitrequest = 1'b1; in_data = 32'd77; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rm_write", 64'(write), 64'd1);
        chk("rm_data", 64'(writedata), 64'd77);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rm_write_low", 64'(write), 64'd0);
        chk("rm_busy_low", 64'(busy), 64'd0);
        chk("rm_ready", 64'(in_ready), 64'd1);
        chk("rm_data_zero", 64'(writedata), 64'd0);
        waitrequest = 1'b0;
        tick();
        tick();
        chk("rm_no_stale", 64'(write), 64'd0);
        chk("rm_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
